// File: rtl/bus_slave_responder_if.sv
// Bit-serial slave bus: the granted master drives address/write data in,
// and the slave returns read data plus a one-cycle completion pulse.
interface bus_slave_responder_if;
  logic sel;
  logic s_valid;
  logic s_in;
  logic s_rd;
  logic s_ready;
  logic s_out;
  logic s_out_valid;
  logic s_ack;

  modport master (
    output sel, s_valid, s_in, s_rd,
    input  s_ready, s_out, s_out_valid, s_ack
  );

  modport slave (
    input  sel, s_valid, s_in, s_rd,
    output s_ready, s_out, s_out_valid, s_ack
  );
endinterface

// File: rtl/bus_slave_responder.sv
// Serial-bus slave: shifts in an LSB-first address (and write data), writes or
// reads a local memory, and returns read data LSB-first after a fixed latency.
module bus_slave_responder #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 2
) (
  input logic clk,
  input logic reset,
  bus_slave_responder_if.slave bus
);

  localparam int MAXW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CW   = $clog2(MAXW);
  localparam int AIW  = $clog2(ADDR_W);
  localparam int DIW  = $clog2(DATA_W);
  localparam int LW   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRITE, RLAT, RDATA} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [LW-1:0]       lat_cnt;
  logic                rd_flag;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   addr_full;
  logic [DATA_W-1:0]   data;
  logic [DATA_W-1:0]   rd_shift;
  logic                s_out_q;
  logic [DATA_W-1:0]   mem [2**ADDR_W];

  // The read snapshot is taken on the same edge that captures the top address bit.
  always_comb begin
    addr_full = addr;
    addr_full[ADDR_W-1] = bus.s_in;
  end

  always_ff @(posedge clk) begin
    if (state == WRITE) mem[addr] <= data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_cnt  <= '0;
      rd_flag  <= 1'b0;
      addr     <= '0;
      data     <= '0;
      rd_shift <= '0;
      s_out_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.sel && bus.s_valid) begin
            addr[0] <= bus.s_in;
            rd_flag <= bus.s_rd;
            cnt     <= CW'(1);
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (!bus.sel) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (bus.s_valid) begin
            addr[cnt[AIW-1:0]] <= bus.s_in;
            if (cnt == CW'(ADDR_W - 1)) begin
              cnt <= '0;
              if (rd_flag) begin
                lat_cnt  <= '0;
                rd_shift <= mem[addr_full];
                state    <= RLAT;
              end else begin
                state <= WDATA;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        WDATA: begin
          if (!bus.sel) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (bus.s_valid) begin
            data[cnt[DIW-1:0]] <= bus.s_in;
            if (cnt == CW'(DATA_W - 1)) begin
              cnt   <= '0;
              state <= WRITE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        WRITE: state <= IDLE;
        RLAT: begin
          if (!bus.sel) begin
            state <= IDLE;
          end else if (lat_cnt == LW'(READ_LATENCY - 1)) begin
            s_out_q  <= rd_shift[0];
            rd_shift <= rd_shift >> 1;
            cnt      <= '0;
            state    <= RDATA;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        // sel is deliberately ignored here: the return slot already belongs to this slave.
        RDATA: begin
          if (cnt == CW'(DATA_W - 1)) begin
            s_out_q <= 1'b0;
            cnt     <= '0;
            state   <= IDLE;
          end else begin
            s_out_q  <= rd_shift[0];
            rd_shift <= rd_shift >> 1;
            cnt      <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s_ready     = (state == IDLE);
  assign bus.s_out_valid = (state == RDATA);
  assign bus.s_ack       = (state == WRITE) || ((state == RDATA) && (cnt == CW'(DATA_W - 1)));
  assign bus.s_out       = s_out_q;

endmodule

// File: tb/tb_bus_slave_responder.sv
// Directed bench for bus_slave_responder: writes, reads, stalls, aborts,
// reset during read data and back-to-back transactions at the address boundary.
module tb_bus_slave_responder;

  logic clk;
  logic reset;
  int   checkCount;
  int   passCount;
  logic [7:0] rdData;

  bus_slave_responder_if bus ();

  bus_slave_responder #(.ADDR_W(12), .DATA_W(8), .READ_LATENCY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleBus();
    bus.sel = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_in = 1'b0;
    bus.s_rd = 1'b0;
  endtask

  task automatic sendBit(input logic b, input logic rd);
    bus.sel = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_in = b;
    bus.s_rd = rd;
    tick();
  endtask

  task automatic stallBus(input logic junk);
    bus.sel = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_in = junk;
    repeat (3) tick();
    checkOutput("stall_busy", bus.s_ready, 1'b0);
  endtask

  // Leaves the bus in the first IDLE cycle so a caller can start back-to-back.
  task automatic writeWord(input logic [11:0] a, input logic [7:0] d,
                           input int stallA, input int stallD, input int abortD);
    for (int i = 0; i < 12; i++) begin
      if (i == stallA) stallBus(~a[i]);
      sendBit(a[i], (i != 0));
      if (i == 0) checkOutput("wr_busy", bus.s_ready, 1'b0);
    end
    for (int j = 0; j < 8; j++) begin
      if (j == abortD) begin
        idleBus();
        tick();
        checkOutput("abort_idle", bus.s_ready, 1'b1);
        checkOutput("abort_noack", bus.s_ack, 1'b0);
        return;
      end
      if (j == stallD) stallBus(~d[j]);
      sendBit(d[j], 1'b1);
    end
    checkOutput("wr_ack", bus.s_ack, 1'b1);
    checkOutput("wr_ack_busy", bus.s_ready, 1'b0);
    tick();
    checkOutput("wr_ack_end", bus.s_ack, 1'b0);
    checkOutput("wr_ready", bus.s_ready, 1'b1);
    idleBus();
  endtask

  task automatic readWord(input logic [11:0] a, output logic [7:0] d, input int resetAt);
    d = 8'h00;
    for (int i = 0; i < 12; i++) sendBit(a[i], (i == 0));
    bus.s_valid = 1'b0;
    bus.sel = 1'b1;
    for (int l = 0; l < 2; l++) begin
      checkOutput("rd_lat_valid", bus.s_out_valid, 1'b0);
      checkOutput("rd_lat_busy", bus.s_ready, 1'b0);
      tick();
    end
    bus.sel = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == resetAt) begin
        reset = 1'b1;
        #1;
        checkOutput("rst_valid", bus.s_out_valid, 1'b0);
        checkOutput("rst_ack", bus.s_ack, 1'b0);
        checkOutput("rst_ready", bus.s_ready, 1'b1);
        tick();
        reset = 1'b0;
        tick();
        return;
      end
      checkOutput("rd_valid", bus.s_out_valid, 1'b1);
      checkOutput("rd_ack", bus.s_ack, (k == 7));
      d[k] = bus.s_out;
      tick();
    end
    checkOutput("rd_done_valid", bus.s_out_valid, 1'b0);
    checkOutput("rd_done_ack", bus.s_ack, 1'b0);
    checkOutput("rd_done_ready", bus.s_ready, 1'b1);
  endtask

  initial begin
    checkCount = 0;
    passCount = 0;
    idleBus();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", bus.s_ready, 1'b1);
    checkOutput("reset_valid", bus.s_out_valid, 1'b0);
    checkOutput("reset_ack", bus.s_ack, 1'b0);
    checkOutput("reset_out", bus.s_out, 1'b0);
    reset = 1'b0;
    tick();

    writeWord(12'd0, 8'hC3, -1, -1, -1);
    writeWord(12'd1002, 8'h5A, -1, -1, -1);

    writeWord(12'd1001, 8'd101, -1, -1, -1);
    readWord(12'd1001, rdData, -1);
    checkOutput("t2_data", rdData, 8'd101);

    writeWord(12'd1001, 8'd102, 5, 3, -1);
    readWord(12'd1001, rdData, -1);
    checkOutput("t3_data", rdData, 8'd102);

    writeWord(12'd1002, 8'hEE, -1, -1, 5);
    readWord(12'd1002, rdData, -1);
    checkOutput("t4_data", rdData, 8'h5A);

    readWord(12'd1001, rdData, 3);
    readWord(12'd1001, rdData, -1);
    checkOutput("t5_data", rdData, 8'd102);

    writeWord(12'd4095, 8'd103, -1, -1, -1);
    readWord(12'd0, rdData, -1);
    checkOutput("t6_addr0", rdData, 8'hC3);
    readWord(12'd4095, rdData, -1);
    checkOutput("t6_top", rdData, 8'd103);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
